// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, field positions and
// fixed vectors used by the arbiter and the register file.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int unsigned SR_IM_HI  = 15;
  localparam int unsigned SR_IM_LO  = 10;
  localparam int unsigned SR_EXL    = 1;
  localparam int unsigned SR_IE     = 0;
  localparam int unsigned CS_BD     = 31;
  localparam int unsigned CS_IP_HI  = 15;
  localparam int unsigned CS_IP_LO  = 10;
  localparam int unsigned CS_EXC_HI = 6;
  localparam int unsigned CS_EXC_LO = 2;

  localparam logic [4:0]  EXC_INT     = 5'd0;
  localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;
  localparam logic [29:0] BUBBLE_PC   = 30'h300;
  localparam logic [31:0] PRID_VALUE  = 32'h4D49_5053;

endpackage

// File: rtl/cp0_int_arbiter.sv
// Combinational arbitration of hardware interrupts against the
// synchronous exception carried by the MEM instruction.
module cp0_int_arbiter
  import cp0_pkg::*;
(
  input  logic [5:0] hwint_i,
  input  logic [5:0] im_i,
  input  logic       ie_i,
  input  logic       exl_i,
  input  logic       valid_i,
  input  logic [4:0] exc_code_m_i,
  output logic       int_pend_o,
  output logic       exc_pend_o,
  output logic       exc_req_o,
  output logic [4:0] exc_code_o
);

  assign int_pend_o = (|(hwint_i & im_i)) & ie_i & ~exl_i & valid_i;
  assign exc_pend_o = (exc_code_m_i != 5'd0) & ~exl_i & valid_i;
  assign exc_req_o  = int_pend_o | exc_pend_o;

  // Interrupt wins when both are pending on the same instruction.
  assign exc_code_o = int_pend_o ? EXC_INT : exc_code_m_i;

endmodule

// File: rtl/cp0_unit.sv
// CP0 register file (SR, Cause, EPC, PRId) with exception entry,
// eret and mtc0 update at the MEM end of the pipeline.
module cp0_unit
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] PC_M,
  input  logic [6:2]  ExcCode_M,
  input  logic        BD_M,
  input  logic        eret_M,
  input  logic        mtc0_M,
  input  logic [4:0]  CP0_addr,
  input  logic [31:0] CP0_Wdata,
  input  logic [5:0]  HWInt,
  output logic [31:0] CP0_RD,
  output logic [31:2] EPC_out,
  output logic        ExcReq
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q;
  logic [4:0]  exc_q, exc_d;
  logic [31:2] epc_q, epc_d;

  logic        valid_m;
  logic        int_pend;
  logic        exc_pend;
  logic [4:0]  exc_sel;
  logic        wr_en;

  assign valid_m = (PC_M != BUBBLE_PC);

  cp0_int_arbiter u_arb (
    .hwint_i      (HWInt),
    .im_i         (im_q),
    .ie_i         (ie_q),
    .exl_i        (exl_q),
    .valid_i      (valid_m),
    .exc_code_m_i (ExcCode_M),
    .int_pend_o   (int_pend),
    .exc_pend_o   (exc_pend),
    .exc_req_o    (ExcReq),
    .exc_code_o   (exc_sel)
  );

  assign wr_en = mtc0_M & valid_m & ~ExcReq;

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    if (ExcReq) begin
      exl_d = 1'b1;
      bd_d  = BD_M;
      exc_d = exc_sel;
      epc_d = BD_M ? (PC_M - 30'd1) : PC_M;
    end else begin
      if (eret_M && valid_m)
        exl_d = 1'b0;
      if (wr_en && CP0_addr == REG_SR) begin
        im_d  = CP0_Wdata[SR_IM_HI:SR_IM_LO];
        exl_d = CP0_Wdata[SR_EXL];
        ie_d  = CP0_Wdata[SR_IE];
      end
      if (wr_en && CP0_addr == REG_EPC)
        epc_d = CP0_Wdata[31:2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= HWInt;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    CP0_RD = '0;
    unique case (CP0_addr)
      REG_SR: begin
        CP0_RD[SR_IM_HI:SR_IM_LO] = im_q;
        CP0_RD[SR_EXL]            = exl_q;
        CP0_RD[SR_IE]             = ie_q;
      end
      REG_CAUSE: begin
        CP0_RD[CS_BD]               = bd_q;
        CP0_RD[CS_IP_HI:CS_IP_LO]   = ip_q;
        CP0_RD[CS_EXC_HI:CS_EXC_LO] = exc_q;
      end
      REG_EPC:  CP0_RD = {epc_q, 2'b00};
      REG_PRID: CP0_RD = PRID_VALUE;
      default:  CP0_RD = '0;
    endcase
  end

  assign EPC_out = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed vector bench for cp0_unit: table of single-instruction
// vectors plus hand sequences for deferral, eret and reset override.
module tb_cp0_unit;

  localparam logic [29:0] BUB  = 30'h300;
  localparam logic [31:0] PRID = 32'h4D49_5053;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:2] PC_M;
  logic [6:2]  ExcCode_M;
  logic        BD_M, eret_M, mtc0_M;
  logic [4:0]  CP0_addr;
  logic [31:0] CP0_Wdata;
  logic [5:0]  HWInt;
  logic [31:0] CP0_RD;
  logic [31:2] EPC_out;
  logic        ExcReq;

  int checks = 0;
  int errors = 0;

  cp0_unit dut (
    .clk       (clk),
    .reset     (reset),
    .PC_M      (PC_M),
    .ExcCode_M (ExcCode_M),
    .BD_M      (BD_M),
    .eret_M    (eret_M),
    .mtc0_M    (mtc0_M),
    .CP0_addr  (CP0_addr),
    .CP0_Wdata (CP0_Wdata),
    .HWInt     (HWInt),
    .CP0_RD    (CP0_RD),
    .EPC_out   (EPC_out),
    .ExcReq    (ExcReq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] pc;
    logic [4:0]  exc;
    logic        bd;
    logic        er;
    logic        mt;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [5:0]  hw;
    logic        req;
    logic [4:0]  raddr;
    logic [31:0] rd;
  } vec_t;

  vec_t tv[18];

  function automatic vec_t mk(
    input logic [29:0] pc, input logic [4:0] exc, input logic bd,
    input logic er, input logic mt, input logic [4:0] addr,
    input logic [31:0] wd, input logic [5:0] hw, input logic req,
    input logic [4:0] raddr, input logic [31:0] rd);
    vec_t v;
    v.pc = pc; v.exc = exc; v.bd = bd; v.er = er; v.mt = mt;
    v.addr = addr; v.wd = wd; v.hw = hw; v.req = req;
    v.raddr = raddr; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [29:0] pc, input logic [4:0] exc,
                       input logic bd, input logic er, input logic mt,
                       input logic [4:0] addr, input logic [31:0] wd,
                       input logic [5:0] hw);
    PC_M = pc; ExcCode_M = exc; BD_M = bd; eret_M = er;
    mtc0_M = mt; CP0_addr = addr; CP0_Wdata = wd; HWInt = hw;
  endtask

  // Idle cycle: bubble in MEM, no controls, interrupt lines held.
  task automatic idle(input logic [4:0] raddr);
    drive(BUB, 5'd0, 1'b0, 1'b0, 1'b0, raddr, 32'h0, HWInt);
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tv[0]  = mk(30'hC00, 0, 0, 0, 1, 12, 32'h0000_FC01, 0, 0, 12, 32'h0000_FC01);
    tv[1]  = mk(30'hC00, 0, 0, 0, 1, 13, 32'hFFFF_FFFF, 0, 0, 13, 32'h0);
    tv[2]  = mk(30'hC00, 0, 0, 0, 1, 12, 32'h0000_0401, 0, 0, 12, 32'h0000_0401);
    tv[3]  = mk(30'hC01, 0, 0, 0, 0, 0, 32'h0, 6'b1, 1, 14, 32'h0000_3004);
    tv[4]  = mk(BUB, 0, 0, 0, 0, 0, 32'h0, 6'b1, 0, 13, 32'h0000_0400);
    tv[5]  = mk(30'hC02, 4, 0, 0, 0, 0, 32'h0, 6'b1, 0, 14, 32'h0000_3004);
    tv[6]  = mk(BUB, 0, 0, 0, 0, 0, 32'h0, 6'b1, 0, 12, 32'h0000_0403);
    tv[7]  = mk(30'hC03, 0, 0, 1, 0, 0, 32'h0, 6'b0, 0, 12, 32'h0000_0401);
    tv[8]  = mk(30'hC04, 10, 1, 0, 0, 0, 32'h0, 6'b1, 1, 14, 32'h0000_300C);
    tv[9]  = mk(BUB, 0, 0, 0, 0, 0, 32'h0, 6'b0, 0, 13, 32'h8000_0000);
    tv[10] = mk(30'hC06, 0, 0, 1, 0, 0, 32'h0, 6'b0, 0, 12, 32'h0000_0401);
    tv[11] = mk(30'hC07, 10, 0, 0, 0, 0, 32'h0, 6'b0, 1, 13, 32'h0000_0028);
    tv[12] = mk(30'hC08, 0, 0, 1, 0, 0, 32'h0, 6'b0, 0, 12, 32'h0000_0401);
    tv[13] = mk(30'hC08, 8, 0, 0, 1, 14, 32'hDEAD_BEEF, 0, 1, 14, 32'h0000_3020);
    tv[14] = mk(30'hC09, 0, 0, 1, 0, 0, 32'h0, 6'b0, 0, 12, 32'h0000_0401);
    tv[15] = mk(30'hC0A, 0, 0, 0, 1, 14, 32'h1234_5678, 0, 0, 14, 32'h1234_5678);
    tv[16] = mk(30'hC0B, 0, 0, 0, 1, 15, 32'hFFFF_FFFF, 0, 0, 15, PRID);
    tv[17] = mk(30'hC0C, 0, 0, 0, 1, 3, 32'hFFFF_FFFF, 0, 0, 3, 32'h0);

    reset = 1'b1;
    drive(BUB, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 6'b0);
    step; step;
    reset = 1'b0;
    #1;
    for (int a = 12; a <= 15; a++) begin
      CP0_addr = 5'(a);
      #1;
      chk($sformatf("reset_rd%0d", a), CP0_RD, (a == 15) ? PRID : 32'h0);
    end
    chk("reset_req", {31'h0, ExcReq}, 32'h0);
    chk("reset_epc_out", {EPC_out, 2'b00}, 32'h0);

    for (int i = 0; i < 18; i++) begin
      drive(tv[i].pc, tv[i].exc, tv[i].bd, tv[i].er, tv[i].mt,
            tv[i].addr, tv[i].wd, tv[i].hw);
      #1;
      chk($sformatf("v%0d_req", i), {31'h0, ExcReq}, {31'h0, tv[i].req});
      if (i == 15)
        chk("rd_during_wr", CP0_RD, 32'h0000_3020);
      step;
      idle(tv[i].raddr);
      #1;
      chk($sformatf("v%0d_rd", i), CP0_RD, tv[i].rd);
    end

    // Interrupt held while MEM carries bubbles is deferred.
    HWInt = 6'b000001;
    for (int k = 0; k < 3; k++) begin
      idle(5'd14);
      #1;
      chk($sformatf("defer_bub%0d", k), {31'h0, ExcReq}, 32'h0);
      step;
    end
    drive(30'hC05, 5'd0, 1'b0, 1'b0, 1'b0, 5'd14, 32'h0, 6'b000001);
    #1;
    chk("defer_rise", {31'h0, ExcReq}, 32'h1);
    step;
    idle(5'd14);
    #1;
    chk("defer_epc", CP0_RD, 32'h0000_3014);
    chk("defer_epc_out", {EPC_out, 2'b00}, 32'h0000_3014);

    // eret with interrupt held: masked now, taken right after.
    drive(30'hC10, 5'd0, 1'b0, 1'b1, 1'b0, 5'd12, 32'h0, 6'b000001);
    #1;
    chk("eret_masked", {31'h0, ExcReq}, 32'h0);
    step;
    drive(30'hC11, 5'd0, 1'b0, 1'b0, 1'b0, 5'd14, 32'h0, 6'b000001);
    #1;
    chk("post_eret_req", {31'h0, ExcReq}, 32'h1);
    step;
    idle(5'd14);
    #1;
    chk("post_eret_epc", CP0_RD, 32'h0000_3044);

    // Reset beats a coincident exception and mtc0.
    drive(30'hC20, 5'd4, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_FC01, 6'b0);
    reset = 1'b1;
    step;
    reset = 1'b0;
    idle(5'd12);
    #1;
    chk("rst_ovr_sr", CP0_RD, 32'h0);
    chk("rst_ovr_epc", {EPC_out, 2'b00}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

The CP0 coprocessor sits at the MEM end of the EX/MEM pipeline boundary. It consumes the exception, eret, mfc0 and mtc0 fields that travel down the pipeline, and it holds the SR, Cause, EPC and PRId registers. It arbitrates hardware interrupts against in-flight exceptions and raises one request that flushes the pipeline and redirects fetch. It also supplies EPC for eret and read data for mfc0.

## Interface
- PRID_VALUE, 32'h4D49_5053: constant returned for PRId (reg 15)
- BUBBLE_PC, 30'h300: PC[31:2] value carried by a flushed pipeline bubble
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- PC_M  in  [31:2]  word PC of the instruction in MEM
- ExcCode_M  in  [6:2]  exception code from upstream; 0 means none
- BD_M  in  1  the MEM instruction sits in a branch delay slot
- eret_M  in  1  the MEM instruction is eret
- mtc0_M  in  1  the MEM instruction is mtc0
- CP0_addr  in  5  CP0 register number (rd field)
- CP0_Wdata  in  32  mtc0 write data
- HWInt  in  6  level-sensitive hardware interrupt lines
- CP0_RD  out  32  combinational read of register CP0_addr
- EPC_out  out  [31:2]  current EPC, for the eret target
- ExcReq  out  1  combinational; flushes IF–MEM and redirects the PC to the handler at 32'h0000_4180 on this edge

## Operation
- SR (12): IM = [15:10], EXL = [1], IE = [0]. All other bits read 0. Writable by mtc0 only in those fields.
- Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]. All other bits read 0. Cause is read-only to mtc0; a write is silently dropped.
- EPC (14): stored as [31:2]; reads as {EPC, 2'b00}. A write stores CP0_Wdata[31:2].
- PRId (15): reads PRID_VALUE; writes are ignored.
- Any other address reads 0; writes to it are ignored.
- valid_M = (PC_M != BUBBLE_PC).
- IntPend = |(HWInt & IM) & IE & !EXL & valid_M.
- ExcPend = (ExcCode_M != 0) & !EXL & valid_M.
- ExcReq = IntPend | ExcPend.
- Priority: an interrupt beats a synchronous exception in the same cycle. Cause.ExcCode = 0 for an interrupt, otherwise ExcCode_M.
- On an edge with ExcReq:
  - EXL <= 1
  - Cause.BD <= BD_M
  - EPC <= BD_M ? PC_M-1 : PC_M (word arithmetic, i.e. PC-4 in bytes; wraps modulo 2^30)
  - Cause.ExcCode is updated as above
- eret_M (valid, no ExcReq): EXL <= 0 on the edge.
- mtc0_M (valid, no ExcReq): write the selected register on the edge. A write to SR.EXL takes effect next cycle.
- When ExcReq and eret or mtc0 coincide, ExcReq wins: the write or EXL clear is suppressed.
- Cause.IP <= HWInt every cycle, unconditionally, including while EXL = 1.
- CP0_RD read-during-write returns the old value.

## Timing
- Reset: SR = 0, Cause = 0, EPC = 0. Outputs after reset: CP0_RD = 0 (PRID_VALUE if addr is 15), EPC_out = 0, ExcReq = 0.
- Reset overrides ExcReq, eret and mtc0 on the same edge.
- ExcReq has zero latency (combinational from inputs and state). State updates land on the same edge as the pipeline flush.
- Cause.IP has one cycle of latency. IntPend uses raw HWInt, not IP.
- An interrupt pending while MEM holds a bubble is deferred: ExcReq stays low until a valid instruction reaches MEM, and that instruction is then the one recorded in EPC.
- With EXL = 1, all interrupts and exceptions are masked, and ExcReq = 0 even when ExcCode_M != 0.
- The eret clear takes effect next cycle. A pending interrupt may assert ExcReq on the first valid instruction after eret.

## Structure
- cp0_pkg holds:
  - register numbers: SR = 12, CAUSE = 13, EPC = 14, PRID = 15
  - field bit positions
  - EXC_INT = 5'd0
  - handler vector 32'h0000_4180
  - BUBBLE_PC
- One sub-module, cp0_int_arbiter, computes IntPend, ExcPend, ExcReq and the chosen ExcCode combinationally. The register file and update logic live in cp0_unit.

## Test plan
- Reset, then read addresses 12, 13, 14, 15 → 0, 0, 0, PRID_VALUE; ExcReq = 0.
- mtc0 to addr 12 with 32'h0000_FC01 → SR reads 32'h0000_FC01. Then mtc0 to addr 13 with 32'hFFFF_FFFF → Cause unchanged.
- SR = 32'h0000_0401, HWInt = 6'b000001, PC_M = 30'h0C01 (byte 0x3004), BD_M = 0:
  - ExcReq = 1 in that cycle
  - next cycle: EPC reads 32'h0000_3004, Cause.ExcCode = 0, EXL = 1
  - eret → EXL = 0 one cycle later
- ExcCode_M = 5'd10 with BD_M = 1 at byte PC 0x3010, with an enabled interrupt on the same cycle → EPC = 0x300C, Cause.BD = 1, ExcCode = 0 (interrupt wins).
- SR = 32'h0000_0401, HWInt = 6'b000001, PC_M = BUBBLE_PC for 3 cycles, then PC_M = 30'h0C05 → ExcReq stays 0 for those 3 cycles, then rises; EPC = 0x3014.
- EXL = 1 and ExcCode_M = 5'd4 → ExcReq = 0, EPC unchanged. Simultaneous ExcReq and mtc0 to EPC → EPC takes the exception PC, not the write data.
